// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/response bundle between execute stage and muldiv_unit
//
// Signals:
//   start     request strobe, sampled only while busy is low
//   alu_ctrl  M-extension operation code
//   op_a      rs1 value (multiplicand / dividend)
//   op_b      rs2 value (multiplier / divisor)
//   busy      operation in flight (pipeline stall)
//   done      one-cycle completion pulse
//   result    final result, held until the next completion
// Modports: master drives the request, slave is the execution unit.
interface muldiv_unit_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ALUCTR_WIDTH = 5
);
    logic                    start;
    logic [ALUCTR_WIDTH-1:0] alu_ctrl;
    logic [DATA_WIDTH-1:0]   op_a;
    logic [DATA_WIDTH-1:0]   op_b;
    logic                    busy;
    logic                    done;
    logic [DATA_WIDTH-1:0]   result;

    modport master (
        output start, alu_ctrl, op_a, op_b,
        input  busy, done, result
    );

    modport slave (
        input  start, alu_ctrl, op_a, op_b,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle RV32M multiply / divide / remainder unit
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    muldiv_unit_if.slave: start/alu_ctrl/op_a/op_b in, busy/done/result out
// Multiplies finish two cycles after accept, normal divides after 33, and
// divide-by-zero / signed overflow resolve in one cycle without iterating.
module muldiv_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int ALUCTR_WIDTH = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_unit_if.slave  bus
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    localparam logic [ALUCTR_WIDTH-1:0] OP_MUL    = ALUCTR_WIDTH'(10);
    localparam logic [ALUCTR_WIDTH-1:0] OP_MULH   = ALUCTR_WIDTH'(11);
    localparam logic [ALUCTR_WIDTH-1:0] OP_MULHSU = ALUCTR_WIDTH'(12);
    localparam logic [ALUCTR_WIDTH-1:0] OP_MULHU  = ALUCTR_WIDTH'(13);
    localparam logic [ALUCTR_WIDTH-1:0] OP_DIV    = ALUCTR_WIDTH'(14);
    localparam logic [ALUCTR_WIDTH-1:0] OP_DIVU   = ALUCTR_WIDTH'(15);
    localparam logic [ALUCTR_WIDTH-1:0] OP_REM    = ALUCTR_WIDTH'(16);
    localparam logic [ALUCTR_WIDTH-1:0] OP_REMU   = ALUCTR_WIDTH'(17);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t state, state_next;

    logic [2*W-1:0]  prod_q;
    logic [W-1:0]    dvd_q;      // dividend shifts out the top, quotient bits shift in the bottom
    logic [W-1:0]    dvs_q;
    logic [W-1:0]    rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic            sel_hi, sel_rem, neg_q, neg_r;
    logic [W-1:0]    result_q;

    // Request decode
    logic is_mul, is_div, accept, div_signed, div_rem, div_zero, div_ovf, special;
    logic [W-1:0] special_res, a_abs, b_abs;

    always_comb begin
        is_mul     = (bus.alu_ctrl >= OP_MUL) && (bus.alu_ctrl <= OP_MULHU);
        is_div     = (bus.alu_ctrl >= OP_DIV) && (bus.alu_ctrl <= OP_REMU);
        accept     = bus.start && (state == IDLE) && (is_mul || is_div);
        div_signed = (bus.alu_ctrl == OP_DIV) || (bus.alu_ctrl == OP_REM);
        div_rem    = (bus.alu_ctrl == OP_REM) || (bus.alu_ctrl == OP_REMU);
        div_zero   = (bus.op_b == '0);
        div_ovf    = div_signed && (bus.op_a == {1'b1, {(W-1){1'b0}}}) && (bus.op_b == '1);
        special    = div_zero || div_ovf;
        if (div_zero)
            special_res = div_rem ? bus.op_a : '1;
        else
            special_res = div_rem ? '0 : bus.op_a;
        a_abs = (div_signed && bus.op_a[W-1]) ? -bus.op_a : bus.op_a;
        b_abs = (div_signed && bus.op_b[W-1]) ? -bus.op_b : bus.op_b;
    end

    // 33-bit extended operands, widened to 64 bits so a plain product is exact mod 2^64
    logic           a_sext, b_sext;
    logic [W:0]     a_ext, b_ext;
    logic [2*W-1:0] a_wide, b_wide, mul_prod;

    always_comb begin
        a_sext   = (bus.alu_ctrl == OP_MULH) || (bus.alu_ctrl == OP_MULHSU);
        b_sext   = (bus.alu_ctrl == OP_MULH);
        a_ext    = {a_sext & bus.op_a[W-1], bus.op_a};
        b_ext    = {b_sext & bus.op_b[W-1], bus.op_b};
        a_wide   = {{(W-1){a_ext[W]}}, a_ext};
        b_wide   = {{(W-1){b_ext[W]}}, b_ext};
        mul_prod = a_wide * b_wide;
    end

    // One restoring-division iteration
    logic [W:0]   shifted, diff;
    logic         q_bit;
    logic [W-1:0] rem_next, q_next, q_fix, r_fix;

    always_comb begin
        shifted  = {rem_q, dvd_q[W-1]};
        diff     = shifted - {1'b0, dvs_q};
        q_bit    = ~diff[W];
        rem_next = q_bit ? diff[W-1:0] : shifted[W-1:0];
        q_next   = {dvd_q[W-2:0], q_bit};
        q_fix    = neg_q ? -q_next : q_next;
        r_fix    = neg_r ? -rem_next : rem_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) begin
                if (is_mul)       state_next = MUL;
                else if (special) state_next = DONE;
                else              state_next = DIV;
            end
            MUL:  state_next = DONE;
            DIV:  if (cnt_q == CNT_LAST) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q   <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            sel_hi   <= 1'b0;
            sel_rem  <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    if (is_mul) begin
                        prod_q <= mul_prod;
                        sel_hi <= (bus.alu_ctrl != OP_MUL);
                    end else if (special) begin
                        result_q <= special_res;
                    end else begin
                        dvd_q   <= a_abs;
                        dvs_q   <= b_abs;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        sel_rem <= div_rem;
                        neg_q   <= div_signed && (bus.op_a[W-1] ^ bus.op_b[W-1]);
                        neg_r   <= div_signed && bus.op_a[W-1];
                    end
                end
                MUL: result_q <= sel_hi ? prod_q[2*W-1:W] : prod_q[W-1:0];
                DIV: begin
                    dvd_q <= q_next;
                    rem_q <= rem_next;
                    cnt_q <= cnt_q + 1'b1;
                    // The last iteration's outputs feed the fix-up directly
                    if (cnt_q == CNT_LAST)
                        result_q <= sel_rem ? r_fix : q_fix;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed-vector bench for muldiv_unit
module tb_muldiv_unit;
    localparam logic [4:0] C_MUL    = 5'b01010;
    localparam logic [4:0] C_MULH   = 5'b01011;
    localparam logic [4:0] C_MULHSU = 5'b01100;
    localparam logic [4:0] C_MULHU  = 5'b01101;
    localparam logic [4:0] C_DIV    = 5'b01110;
    localparam logic [4:0] C_DIVU   = 5'b01111;
    localparam logic [4:0] C_REM    = 5'b10000;
    localparam logic [4:0] C_REMU   = 5'b10001;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    muldiv_unit_if #(.DATA_WIDTH(32), .ALUCTR_WIDTH(5)) bus ();

    muldiv_unit #(.DATA_WIDTH(32), .ALUCTR_WIDTH(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents a request for one cycle, then scrambles the inputs
    task automatic start_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.alu_ctrl = code;
        bus.op_a     = a;
        bus.op_b     = b;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.alu_ctrl = C_DIV;
        bus.op_a     = 32'h5A5A5A5A;
        bus.op_b     = 32'hA5A5A5A5;
    endtask

    // Latency counted from T; busy must be high every cycle up to and including done
    task automatic wait_done(output int lat, output int busy_bad);
        lat = -1;
        busy_bad = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (!bus.busy) busy_bad++;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [4:0] code, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat, bad;
        start_op(code, a, b);
        wait_done(lat, bad);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy"}, bad, 0);
        check({tag, "_res"}, bus.result, exp);
        @(negedge clk);
        check({tag, "_idle"}, {30'd0, bus.busy, bus.done}, 0);
        check({tag, "_hold"}, bus.result, exp);
    endtask

    initial begin
        int lat, bad, extra;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.alu_ctrl = '0;
        bus.op_a     = '0;
        bus.op_b     = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 0);
        check("rst_done", {31'd0, bus.done}, 0);
        check("rst_result", bus.result, 0);
        rst_n = 1'b1;

        run_op("mul",     C_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2);
        run_op("mulh",    C_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 2);
        run_op("mulhu",   C_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2);
        run_op("mulhsu",  C_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2);
        run_op("div",     C_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        run_op("rem",     C_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        run_op("divu",    C_DIVU,   32'd100,      32'd7,        32'd14,       33);
        run_op("remu",    C_REMU,   32'd100,      32'd7,        32'd2,        33);
        run_op("divu_z",  C_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_op("rem_z",   C_REM,    32'd5,        32'd0,        32'd5,        1);
        run_op("div_ovf", C_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("rem_ovf", C_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

        // New request at T+5 of a running DIVU must be dropped
        start_op(C_DIVU, 32'd100, 32'd7);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 5) begin
                bus.start    = 1'b1;
                bus.alu_ctrl = C_MUL;
                bus.op_a     = 32'd9;
                bus.op_b     = 32'd9;
            end
            if (k == 6) bus.start = 1'b0;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        check("busy_ign_lat", lat, 33);
        check("busy_ign_res", bus.result, 32'd14);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) extra++;
        end
        check("busy_ign_nodone", extra, 0);

        // Invalid code is never accepted
        @(negedge clk);
        bus.start    = 1'b1;
        bus.alu_ctrl = 5'b00000;
        bus.op_a     = 32'd3;
        bus.op_b     = 32'd3;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done || bus.busy) extra++;
        end
        bus.start = 1'b0;
        check("bad_code", extra, 0);
        check("bad_code_res", bus.result, 32'd14);

        // Reset mid-divide
        start_op(C_DIV, 32'hFFFFFFF9, 32'd2);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, bus.busy}, 0);
        check("arst_done", {31'd0, bus.done}, 0);
        check("arst_result", bus.result, 0);
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) extra++;
        end
        check("arst_nodone", extra, 0);
        rst_n = 1'b1;
        run_op("post_rst_mul", C_MUL, 32'd3, 32'd4, 32'd12, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle RV32M execution unit sitting directly downstream of the ALU control decoder in the execute stage. It consumes the 5-bit ALU control code for the eight M-extension operations and returns a 32-bit result through a start/busy/done handshake. Multiplies complete in two cycles. Divides and remainders use a 32-iteration restoring divider. The hazard unit stalls the pipeline while `busy` is high.

## Interface
Parameters:
- `DATA_WIDTH`, 32, operand and result width.
- `ALUCTR_WIDTH`, 5, width of the ALU control code.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request; sampled only when `busy` is low.
- `alu_ctrl`  in  ALUCTR_WIDTH  operation code; latched at accept.
- `op_a`  in  DATA_WIDTH  rs1 value (multiplicand or dividend); latched at accept.
- `op_b`  in  DATA_WIDTH  rs2 value (multiplier or divisor); latched at accept.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse; `result` is valid from this cycle.
- `result`  out  DATA_WIDTH  final result; held until the next completion.

## Operation
Operation codes:
- 01010 MUL: low word of the product.
- 01011 MULH: high word, signed × signed.
- 01100 MULHSU: high word, signed `op_a` × unsigned `op_b`.
- 01101 MULHU: high word, unsigned × unsigned.
- 01110 DIV and 01111 DIVU: signed and unsigned quotient.
- 10000 REM and 10001 REMU: signed and unsigned remainder.
- Any other code with `start` high is ignored: no accept, `busy` stays low, no `done`.

State machine:
- States are IDLE, MUL, DIV and DONE.
- IDLE → MUL on accept of a multiply code.
- IDLE → DIV on accept of a normal divide or remainder.
- IDLE → DONE directly on accept of a special-case divide or remainder.
- MUL → DONE after one cycle.
- DIV → DONE after exactly 32 iterations.
- DONE → IDLE unconditionally.

Multiply rules:
- Build a 64-bit product from 33-bit sign- or zero-extended operands.
- Register the product in the MUL state.
- Select the low or high word on the MUL → DONE transition.

Divide rules:
- Signed operations divide absolute values.
- Quotient is negated when the operand signs differ.
- Remainder takes the sign of the dividend.
- Each iteration shifts one dividend bit into a 33-bit partial remainder and subtracts the divisor. If the result is non-negative, the difference is kept and the quotient bit is 1.
- Sign fix-up is applied on the DIV → DONE transition.

Special cases, all resolved without iterating:
- Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give `op_a`.
- Signed overflow (0x80000000 / 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.

Boundary rules:
- `start` while `busy` is high is ignored; latched operands are not disturbed.
- `start` in the DONE cycle is ignored.
- Changes on the input ports after accept have no effect on the operation.
- Reset asserted mid-operation aborts immediately: state returns to IDLE and all outputs go to their reset values.

## Timing
- T is the cycle in which `start` is sampled high with a valid code and `busy` low.
- Reset values: `busy`=0, `done`=0, `result`=0, state IDLE.
- Latency N is the cycle in which `done` is high:
  - multiply: N = T+2;
  - normal divide or remainder: N = T+33 (DIV state occupies T+1..T+32);
  - special-case divide or remainder: N = T+1.
- `busy` is high from T+1 through N inclusive, and low from N+1.
- The earliest next accept is N+1.
- `done` is high only in cycle N.
- `result` updates at the edge entering cycle N and is stable afterwards until the next completion.

## Test plan
- MUL 7 × 0xFFFFFFFD → `result` 0xFFFFFFEB; `done` only at T+2; `busy` high T+1..T+2.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD, and REM on the same operands → 0xFFFFFFFF, each at T+33. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- Special cases, each with `done` at T+1:
  - DIVU 5 / 0 → 0xFFFFFFFF;
  - REM 5 / 0 → 5;
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000;
  - REM on the same operands → 0.
- Ignored requests:
  - `start` pulsed at T+5 of a running DIV with new operands → first result unchanged and no second `done`;
  - `start` with code 00000 → `busy` stays 0 and no `done`.
- Reset:
  - `rst_n` low at T+10 of a DIV → `busy`, `done` and `result` drop to 0 immediately with no `done` pulse;
  - after release, MUL 3 × 4 → 12 at T'+2.
